cordic_atan_prefold: RTL and testbench

Upstream input stage of the CORDIC arctangent path. Accepts signed (x, y) vectors over a valid/ready stream and folds every vector into the right half-plane (x ≥ 0), which is the convergence range of the vectoring core. It emits a quadrant-correction code that the angle post-stage uses to add ±π, and flags the undefined zero vector. A 2-entry output FIFO decouples it from core back-pressure while sustaining one vector per cycle.

---
 rtl/cordic_atan_prefold.sv | 109 ++++++++++
 tb/tb_cordic_atan_prefold.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan_prefold.sv
// Input pre-fold stage for the CORDIC arctangent path: folds (x, y) into the
// right half-plane, tags the +/-pi correction and the zero vector, buffers 2 deep.
module cordic_atan_prefold #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W:0]   out_x,
  output logic signed [DATA_W:0]   out_y,
  output logic [1:0]               out_quad,
  output logic                     out_zero,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int OUT_W = DATA_W + 1;

  typedef enum logic [1:0] {
    QUAD_NONE   = 2'b00,
    QUAD_ADD_PI = 2'b01,
    QUAD_SUB_PI = 2'b10
  } quad_e;

  typedef struct packed {
    logic signed [OUT_W-1:0] x;
    logic signed [OUT_W-1:0] y;
    quad_e                   quad;
    logic                    zero;
  } entry_t;

  logic signed [OUT_W-1:0] ext_x;
  logic signed [OUT_W-1:0] ext_y;
  entry_t                  fold;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Widen before negating so the most negative input folds without wrapping.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    ext_x     = {in_x[DATA_W-1], in_x};
    ext_y     = {in_y[DATA_W-1], in_y};
    fold.x    = ext_x;
    fold.y    = ext_y;
    fold.quad = QUAD_NONE;
    fold.zero = (in_x == '0) && (in_y == '0);
    if (in_x[DATA_W-1]) begin
      fold.x    = -ext_x;
      fold.y    = -ext_y;
      fold.quad = in_y[DATA_W-1] ? QUAD_SUB_PI : QUAD_ADD_PI;
    end
  end

  // Readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = resetn & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: the storage is reset as well because the head entry drives out_*
  // directly and must read as all-zero straight out of reset; non-blocking
  // assignments keep every register update order-independent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= fold;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A write never targets the head slot while it is valid, so the head holds
  // steady under back-pressure.
  assign out_x    = mem[rd_ptr].x;
  assign out_y    = mem[rd_ptr].y;
  assign out_quad = mem[rd_ptr].quad;
  assign out_zero = mem[rd_ptr].zero;

endmodule

// File: tb/tb_cordic_atan_prefold.sv
// Directed bench for cordic_atan_prefold: fold cases, extremes, zero vector,
// back-pressure, full-rate streaming and reset in mid-operation.
module tb_cordic_atan_prefold;

  localparam int DATA_W = 16;

  logic                     clk;
  logic                     resetn;
  logic signed [DATA_W-1:0] in_x;
  logic signed [DATA_W-1:0] in_y;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W:0]   out_x;
  logic signed [DATA_W:0]   out_y;
  logic [1:0]               out_quad;
  logic                     out_zero;
  logic                     out_valid;
  logic                     out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_atan_prefold #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_quad  (out_quad),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic chk_head(input string tag, input int ex, input int ey,
                          input int eq, input int ez);
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".x"},     int'(out_x),     ex);
    chk({tag, ".y"},     int'(out_y),     ey);
    chk({tag, ".quad"},  int'(out_quad),  eq);
    chk({tag, ".zero"},  int'(out_zero),  ez);
  endtask

  task automatic drive(input int x, input int y);
    in_x     = DATA_W'(x);
    in_y     = DATA_W'(y);
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector in, check the head one edge later, then let it drain.
  task automatic single(input string tag, input int x, input int y,
                        input int ex, input int ey, input int eq, input int ez);
    drive(x, y);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_head(tag, ex, ey, eq, ez);
    tick();
    chk({tag, ".drained"}, int'(out_valid), 0);
  endtask

  initial begin
    resetn    = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.in_ready",  int'(in_ready),  0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_x",     int'(out_x),     0);
    chk("rst.out_y",     int'(out_y),     0);
    chk("rst.out_quad",  int'(out_quad),  0);
    chk("rst.out_zero",  int'(out_zero),  0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rel.in_ready",  int'(in_ready),  1);
    chk("rel.out_valid", int'(out_valid), 0);

    // Basic folds and axis/extreme cases
    single("q0",     3,      4,      3,     4,     0, 0);
    single("q1",    -3,      4,      3,    -4,     1, 0);
    single("q2",    -3,     -4,      3,     4,     2, 0);
    single("negx",  -5,      0,      5,     0,     1, 0);
    single("negy",   0,     -7,      0,    -7,     0, 0);
    single("min",   -32768, -32768,  32768, 32768, 2, 0);
    single("zero",   0,      0,      0,     0,     0, 1);
    single("after0", 1,      1,      1,     1,     0, 0);

    // Back-pressure: A and B fill the FIFO, C is stalled
    out_ready = 1'b0;
    drive(10, 20);
    tick();
    chk("bp.a.in_ready", int'(in_ready), 1);
    chk_head("bp.a", 10, 20, 0, 0);
    drive(-11, 5);
    tick();
    chk("bp.b.in_ready", int'(in_ready), 0);
    chk_head("bp.b_hold", 10, 20, 0, 0);
    drive(12, -13);
    tick();
    chk("bp.c.in_ready", int'(in_ready), 0);
    chk_head("bp.c_hold", 10, 20, 0, 0);
    out_ready = 1'b1;
    tick();
    chk("bp.pop1.in_ready", int'(in_ready), 1);
    chk_head("bp.out_b", 11, -5, 1, 0);
    tick();
    in_valid = 1'b0;
    chk_head("bp.out_c", 12, -13, 0, 0);
    tick();
    chk("bp.empty", int'(out_valid), 0);

    // Full-rate streaming with out_ready held high
    drive(100, -1);
    tick();
    chk("st0.in_ready", int'(in_ready), 1);
    chk_head("st0", 100, -1, 0, 0);
    drive(-100, -1);
    tick();
    chk("st1.in_ready", int'(in_ready), 1);
    chk_head("st1", 100, 1, 2, 0);
    drive(-1, 7);
    tick();
    chk("st2.in_ready", int'(in_ready), 1);
    chk_head("st2", 1, -7, 1, 0);
    drive(7, -100);
    tick();
    in_valid = 1'b0;
    chk_head("st3", 7, -100, 0, 0);
    tick();
    chk("st.empty", int'(out_valid), 0);

    // Reset mid-operation with the FIFO full
    out_ready = 1'b0;
    drive(5, 5);
    tick();
    drive(6, 6);
    tick();
    in_valid = 1'b0;
    chk("mid.full.in_ready", int'(in_ready), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid.rst.out_valid", int'(out_valid), 0);
    chk("mid.rst.in_ready",  int'(in_ready),  0);
    chk("mid.rst.out_x",     int'(out_x),     0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid.rst3.in_ready", int'(in_ready), 0);
    resetn = 1'b1;
    #1;
    chk("mid.rel.in_ready",  int'(in_ready),  1);
    chk("mid.rel.out_valid", int'(out_valid), 0);
    drive(2, -2);
    tick();
    in_valid = 1'b0;
    chk_head("mid.first", 2, -2, 0, 0);
    out_ready = 1'b1;
    tick();
    chk("mid.drained", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
